// File: rtl/multi_button_input.sv
// multi_button_input: per-channel 2-flop sync, counter debounce, short/long/auto-repeat press
// classification and a lowest-index event encoder. Pulses follow the level edge that causes them
// in the same cycle; the encoded event lands one cycle later. No backpressure: events not taken are lost.
// Auto-repeat is compiled in only when MULTI_BUTTON_INPUT_AUTO_REPEAT_EN is defined.
module multi_button_input #(
  parameter int N_CH          = 5,
  parameter int DEB_CYCLES    = 16,
  parameter int LONG_CYCLES   = 32,
  parameter int REPEAT_CYCLES = 8,
  localparam int MAXC = (DEB_CYCLES > LONG_CYCLES)
                        ? ((DEB_CYCLES > REPEAT_CYCLES) ? DEB_CYCLES : REPEAT_CYCLES)
                        : ((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES),
  localparam int CW   = $clog2(MAXC + 1),
  localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_100,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] short_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] rpt_p,
  output logic            evt_valid,
  output logic [IW-1:0]   evt_ch,
  output logic [1:0]      evt_type
);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG} state_t;

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] level_q, level_d;
  logic [CW-1:0]   deb_cnt_q [N_CH];
  logic [CW-1:0]   deb_cnt_d [N_CH];
  state_t          state_q   [N_CH];
  state_t          state_d   [N_CH];
  logic [CW-1:0]   hold_cnt_q [N_CH];
  logic [CW-1:0]   hold_cnt_d [N_CH];
  logic [N_CH-1:0] short_q, short_d, long_q, long_d, rpt_q, rpt_d;
  logic            evt_valid_q, evt_valid_d;
  logic [IW-1:0]   evt_ch_q, evt_ch_d;
  logic [1:0]      evt_type_q, evt_type_d;

  // Two-flop synchroniser for the raw asynchronous button levels.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level follows the synchronised bit only after DEB_CYCLES consecutive mismatches.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_CH; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          level_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Press classifier: reacts to the debounced edge in the cycle it is taken, so pulses line up with level.
  always_comb begin
    short_d = '0;
    long_d  = '0;
    rpt_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i]    = state_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (level_d[i] && !level_q[i]) begin
            state_d[i]    = ST_HELD;
            hold_cnt_d[i] = '0;
          end
        end
        ST_HELD: begin
          // Release is checked first so a release on the threshold cycle still counts as short.
          if (!level_d[i]) begin
            short_d[i]    = 1'b1;
            state_d[i]    = ST_IDLE;
            hold_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] == CW'(LONG_CYCLES - 1)) begin
            long_d[i]     = 1'b1;
            state_d[i]    = ST_LONG;
            hold_cnt_d[i] = '0;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
          end
        end
        ST_LONG: begin
          if (!level_d[i]) begin
            state_d[i]    = ST_IDLE;
            hold_cnt_d[i] = '0;
          end
`ifdef MULTI_BUTTON_INPUT_AUTO_REPEAT_EN
          else if (hold_cnt_q[i] == CW'(REPEAT_CYCLES - 1)) begin
            rpt_d[i]      = 1'b1;
            hold_cnt_d[i] = '0;
          end else begin
            hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
          end
`endif
        end
        default: begin
          state_d[i]    = ST_IDLE;
          hold_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Event encoder: lowest-index channel with a pulse wins; higher channels stay on the vectors only.
  always_comb begin
    evt_valid_d = 1'b0;
    evt_ch_d    = '0;
    evt_type_d  = 2'b00;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (short_q[i] || long_q[i] || rpt_q[i]) begin
        evt_valid_d = 1'b1;
        evt_ch_d    = IW'(i);
        if (short_q[i])     evt_type_d = 2'b01;
        else if (long_q[i]) evt_type_d = 2'b10;
        else                evt_type_d = 2'b11;
      end
    end
  end

  // State and output registers; reset clears everything so a press in progress is discarded.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      short_q     <= '0;
      long_q      <= '0;
      rpt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_type_q  <= 2'b00;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
        state_q[i]    <= ST_IDLE;
      end
    end else begin
      level_q     <= level_d;
      short_q     <= short_d;
      long_q      <= long_d;
      rpt_q       <= rpt_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_type_q  <= evt_type_d;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  assign level     = level_q;
  assign short_p   = short_q;
  assign long_p    = long_q;
  assign rpt_p     = rpt_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_type  = evt_type_q;

endmodule

// File: tb/tb_multi_button_input.sv
// Bench for multi_button_input: directed scenarios with hand-computed timings plus a randomized
// phase, all checked each cycle against a press-timing model of the button front end.
module tb_multi_button_input;

  localparam int NC   = 4;
  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int REP  = 8;
`ifdef MULTI_BUTTON_INPUT_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk_100 = 1'b0;
  logic          rst_n;
  logic [NC-1:0] btn_in;
  logic [NC-1:0] level, short_p, long_p, rpt_p;
  logic          evt_valid;
  logic [1:0]    evt_ch;
  logic [1:0]    evt_type;

  multi_button_input #(
    .N_CH(NC), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk_100(clk_100), .rst_n(rst_n), .btn_in(btn_in),
    .level(level), .short_p(short_p), .long_p(long_p), .rpt_p(rpt_p),
    .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_type(evt_type)
  );

  always #5 clk_100 = ~clk_100;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Level changes once the synchronised input (input delayed two clocks) has disagreed with it
  // for DEB consecutive samples. A press is timed from its level rise: a release within LNG
  // cycles is short; still held LNG cycles after the rise is long; with repeat, every REP
  // cycles after that while still held.
  bit [NC-1:0] h [0:DEB+1];   // h[j] = input sampled j edges ago (h[0] = this edge)
  bit [NC-1:0] m_lvl, e_short, e_long, e_rpt;
  bit          e_vld;
  int          e_ch, e_type;
  int          rise_t [NC];
  int          k;

  always @(posedge clk_100) begin
    bit [NC-1:0] ps, pl, pr;
    cyc++;
    if (!rst_n) begin
      for (int j = 0; j <= DEB + 1; j++) h[j] = '0;
      m_lvl = '0; e_short = '0; e_long = '0; e_rpt = '0;
      e_vld = 1'b0; e_ch = 0; e_type = 0; k = 0;
      for (int c = 0; c < NC; c++) rise_t[c] = 0;
    end else begin
      k++;
      for (int j = DEB + 1; j > 0; j--) h[j] = h[j-1];
      h[0] = btn_in;
      ps = e_short; pl = e_long; pr = e_rpt;
      e_vld = 1'b0; e_ch = 0; e_type = 0;
      for (int c = NC - 1; c >= 0; c--) begin
        if (ps[c] || pl[c] || pr[c]) begin
          e_vld = 1'b1; e_ch = c;
          e_type = ps[c] ? 1 : (pl[c] ? 2 : 3);
        end
      end
      for (int c = 0; c < NC; c++) begin
        bit chg, old;
        chg = 1'b1;
        for (int j = 2; j <= DEB + 1; j++) if (h[j][c] == m_lvl[c]) chg = 1'b0;
        old = m_lvl[c];
        if (chg) m_lvl[c] = h[2][c];
        e_short[c] = 1'b0; e_long[c] = 1'b0; e_rpt[c] = 1'b0;
        if (!old && m_lvl[c]) rise_t[c] = k;
        if (old && !m_lvl[c] && (k - rise_t[c] <= LNG)) e_short[c] = 1'b1;
        if (m_lvl[c] && (k - rise_t[c] == LNG)) e_long[c] = 1'b1;
        if (REP_EN && m_lvl[c] && (k - rise_t[c] > LNG) && ((k - rise_t[c] - LNG) % REP == 0))
          e_rpt[c] = 1'b1;
      end
    end
  end

  // ---------------- compare + observation ----------------
  int rise_cyc [NC], short_cyc [NC], long_cyc [NC];
  int rise_cnt [NC], short_cnt [NC], long_cnt [NC], rpt_cnt [NC];
  int evt_cnt, last_evt_ch, last_evt_type, last_evt_cyc;
  logic [NC-1:0] prev_level = '0;

  always @(posedge clk_100) begin
    #2;
    chk("level",    int'(level),     int'(m_lvl));
    chk("short_p",  int'(short_p),   int'(e_short));
    chk("long_p",   int'(long_p),    int'(e_long));
    chk("rpt_p",    int'(rpt_p),     int'(e_rpt));
    chk("evt_valid", int'(evt_valid), int'(e_vld));
    chk("evt_ch",   int'(evt_ch),    e_ch);
    chk("evt_type", int'(evt_type),  e_type);
    for (int c = 0; c < NC; c++) begin
      if (level[c] && !prev_level[c]) begin rise_cnt[c]++; rise_cyc[c] = cyc; end
      if (short_p[c]) begin short_cnt[c]++; short_cyc[c] = cyc; end
      if (long_p[c])  begin long_cnt[c]++;  long_cyc[c]  = cyc; end
      if (rpt_p[c])   rpt_cnt[c]++;
    end
    if (evt_valid) begin
      evt_cnt++; last_evt_ch = int'(evt_ch); last_evt_type = int'(evt_type); last_evt_cyc = cyc;
    end
    prev_level = level;
  end

  task automatic clear_obs();
    for (int c = 0; c < NC; c++) begin
      rise_cyc[c] = -1000; short_cyc[c] = -1000; long_cyc[c] = -1000;
      rise_cnt[c] = 0; short_cnt[c] = 0; long_cnt[c] = 0; rpt_cnt[c] = 0;
    end
    evt_cnt = 0; last_evt_ch = -1; last_evt_type = -1; last_evt_cyc = -1000;
  endtask

  task automatic press(input int c, input int n, output int t0);
    btn_in[c] = 1'b1;
    t0 = cyc;
    repeat (n) @(negedge clk_100);
    btn_in[c] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int t0, t1;
  int rem [NC];

  initial begin
    rst_n  = 1'b0;
    btn_in = '0;
    clear_obs();
    repeat (3) @(negedge clk_100);
    chk("reset_outputs", int'({level, short_p, long_p, rpt_p, evt_valid, evt_ch, evt_type}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_100);

    // Glitch of 3 cycles on channel 1: too short to debounce.
    clear_obs();
    press(1, 3, t0);
    repeat (20) @(negedge clk_100);
    chk("glitch_rise", rise_cnt[1], 0);
    chk("glitch_pulses", short_cnt[1] + long_cnt[1] + rpt_cnt[1] + evt_cnt, 0);

    // Short press on channel 2 for 10 cycles.
    clear_obs();
    press(2, 10, t0);
    repeat (25) @(negedge clk_100);
    chk("short_rise_delay", rise_cyc[2] - t0, 6);
    chk("short_count", short_cnt[2], 1);
    chk("short_release_cyc", short_cyc[2] - t0, 16);
    chk("short_evt_delay", last_evt_cyc - short_cyc[2], 1);
    chk("short_evt_ch", last_evt_ch, 2);
    chk("short_evt_type", last_evt_type, 1);

    // Long press on channel 0 for 60 cycles.
    clear_obs();
    press(0, 60, t0);
    repeat (25) @(negedge clk_100);
    chk("long_count", long_cnt[0], 1);
    chk("long_after_rise", long_cyc[0] - rise_cyc[0], 20);
    chk("long_rpt_count", rpt_cnt[0], REP_EN ? 4 : 0);
    chk("long_no_short", short_cnt[0], 0);
    chk("long_evt_count", evt_cnt, REP_EN ? 5 : 1);

    // Channels 1 and 3 released together after short presses.
    clear_obs();
    btn_in[1] = 1'b1; btn_in[3] = 1'b1;
    t0 = cyc;
    repeat (8) @(negedge clk_100);
    btn_in[1] = 1'b0; btn_in[3] = 1'b0;
    repeat (20) @(negedge clk_100);
    chk("sim_short1_cyc", short_cyc[1] - t0, 14);
    chk("sim_short3_cyc", short_cyc[3] - t0, 14);
    chk("sim_evt_count", evt_cnt, 1);
    chk("sim_evt_ch", last_evt_ch, 1);

    // Boundary: level high exactly 20 cycles is short; 21 cycles is long.
    clear_obs();
    press(3, 20, t0);
    repeat (20) @(negedge clk_100);
    chk("bound20_short", short_cnt[3], 1);
    chk("bound20_long", long_cnt[3], 0);
    clear_obs();
    press(3, 21, t0);
    repeat (20) @(negedge clk_100);
    chk("bound21_short", short_cnt[3], 0);
    chk("bound21_long", long_cnt[3], 1);

    // Reset at held cycle 10 with the button kept high.
    clear_obs();
    btn_in[0] = 1'b1;
    t0 = cyc;
    repeat (16) @(negedge clk_100);
    chk("pre_reset_level0", int'(level[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_midhold_outputs",
        int'({level, short_p, long_p, rpt_p, evt_valid, evt_ch, evt_type}), 0);
    repeat (2) @(negedge clk_100);
    rst_n = 1'b1;
    t1 = cyc;
    clear_obs();
    repeat (35) @(negedge clk_100);
    chk("rst_new_rise", rise_cyc[0] - t1, 6);
    chk("rst_long_after_rise", long_cyc[0] - rise_cyc[0], 20);
    chk("rst_no_short", short_cnt[0], 0);
    btn_in[0] = 1'b0;
    repeat (20) @(negedge clk_100);

    // Randomized phase: glitches, short, boundary and long presses on all channels.
    for (int c = 0; c < NC; c++) rem[c] = $urandom_range(1, 30);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_100);
      if (n == 1500) rst_n = 1'b0;
      if (n == 1502) rst_n = 1'b1;
      for (int c = 0; c < NC; c++) begin
        if (rem[c] == 0) begin
          btn_in[c] = !btn_in[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(3, 45);
        end else begin
          rem[c]--;
        end
      end
    end
    btn_in = '0;
    repeat (40) @(negedge clk_100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_button_input.md
MULTI_BUTTON_INPUT -- requirements
Module: multi_button_input

Interface
REQ-001 Parameter N_CH, default 5: number of push-button channels, legal range 1..16.
REQ-002 Parameter DEB_CYCLES, default 16: cycles of stable synchronised input needed to change the debounced level, minimum 2.
REQ-003 Parameter LONG_CYCLES, default 32: held cycles that classify a press as long, minimum 2.
REQ-004 Parameter REPEAT_CYCLES, default 8: auto-repeat period in cycles after a long press, minimum 2.
REQ-005 Localparam CW = clog2(max(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1); localparam IW = max(1, clog2(N_CH)).
REQ-006 clk_100  input  1  system clock; all state is on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 btn_in  input  N_CH  raw asynchronous button levels, active-high.
REQ-009 level  output  N_CH  debounced button levels.
REQ-010 short_p  output  N_CH  one-cycle pulse per channel on release of a short press.
REQ-011 long_p  output  N_CH  one-cycle pulse per channel when a hold reaches LONG_CYCLES.
REQ-012 rpt_p  output  N_CH  one-cycle auto-repeat pulse per channel.
REQ-013 evt_valid  output  1  registered strobe: an event was encoded this cycle.
REQ-014 evt_ch  output  IW  channel index of the encoded event.
REQ-015 evt_type  output  2  event type: 01 short, 10 long, 11 repeat, 00 none.

Function
REQ-016 Each btn_in bit SHALL pass through a 2-flop synchroniser before debounce.
REQ-017 Debounce SHALL use a per-channel CW-bit counter:
- counter cleared whenever the synchronised bit equals level;
- counter incremented otherwise;
- when the counter equals DEB_CYCLES-1 while incrementing, level takes the synchronised value and the counter clears.
REQ-018 A glitch shorter than DEB_CYCLES cycles SHALL never change level.
REQ-019 Each channel SHALL run a 3-state FSM (IDLE, HELD, LONG) with a CW-bit hold counter.
REQ-020 IDLE: level rising -> HELD, counter = 0.
REQ-021 HELD: counter increments each cycle while level = 1.
- level falls -> short_p = 1 for one cycle, then IDLE.
- counter reaches LONG_CYCLES-1 with level = 1 -> long_p = 1 for one cycle, counter = 0, then LONG.
REQ-022 In HELD, if level falls in the same cycle the threshold is reached, short_p SHALL win and long_p SHALL stay 0.
REQ-023 LONG: level falls -> IDLE with no pulse; repeat behaviour follows REQ-030/031.
REQ-024 Counters SHALL never wrap: each is cleared or stops at its threshold.
REQ-025 short_p, long_p and rpt_p SHALL be registered; at most one of them is high per channel per cycle.
REQ-026 The event encoder SHALL select the lowest-index channel with any pulse high and register it one cycle later: evt_valid = 1, evt_ch = index, evt_type per REQ-015.
- Simultaneous pulses on higher channels appear only on the vector outputs.
- With no pulse, evt_valid = 0, evt_ch = 0, evt_type = 00.

Reset
REQ-027 On rst_n low, all outputs SHALL go to 0 immediately; synchronisers, debounce counters, level, FSMs (IDLE) and hold counters SHALL clear.
REQ-028 A reset asserted mid-press SHALL discard the press; after release of reset, a button still held SHALL debounce in as a new press.

Configuration
REQ-029 Macro MULTI_BUTTON_INPUT_AUTO_REPEAT_EN selects whether auto-repeat is compiled in.
REQ-030 With the macro defined, in LONG:
- the counter increments while level = 1;
- at REPEAT_CYCLES-1, rpt_p = 1 for one cycle and the counter clears;
- a release in that same cycle suppresses rpt_p.
REQ-031 Without the macro, rpt_p SHALL be tied to 0, the LONG counter stays 0, and evt_type 11 never occurs.

Verification
All scenarios use N_CH=4, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
REQ-032 Glitch: btn_in[1] high for 3 cycles -> level[1] stays 0; no pulses.
REQ-033 Short press: btn_in[2] high for 10 cycles -> level[2] rises 6 cycles after the input edge; short_p[2] pulses once at release; next cycle evt_ch = 2, evt_type = 01.
REQ-034 Long press with repeat (macro defined): btn_in[0] held 60 cycles -> long_p[0] at held cycle 20, then rpt_p[0] every 8 cycles; no short_p at release. Without the macro: long_p[0] only.
REQ-035 Simultaneous events: channels 1 and 3 released in the same cycle after short presses -> both short_p bits high; evt_ch = 1 only.
REQ-036 Boundary: level falls in the cycle the hold counter equals 19 -> short_p = 1, long_p = 0.
REQ-037 Reset mid-hold: rst_n low for 2 cycles at held cycle 10 with button kept high -> all outputs 0 during reset; press restarts and long_p fires 20 cycles after the new level rise.
